// File: rtl/dds_wave_meter.sv
// dds_wave_meter: measures a signed sample stream. Rising zero crossings are
// detected with hysteresis, and the sclk count spanned by 2**AVG_LOG2 periods is
// accumulated per window together with the signal min, max and peak-to-peak.
//
// Ports
//   sclk        system clock, rising edge
//   rst         asynchronous active-high reset
//   meas_en     level enable; 0 forces IDLE
//   din         signed sample, DATA_BIT wide
//   din_en      din valid strobe
//   period_sum  sclk cycles spanned by the last complete window
//   pk_max      signed maximum over the last window
//   pk_min      signed minimum over the last window
//   pk_p2p      unsigned pk_max - pk_min, DATA_BIT+1 wide
//   meas_valid  one-cycle pulse when the results update
//   no_signal   set on timeout, cleared by meas_valid or meas_en=0
//   busy        state != IDLE
module dds_wave_meter #(
    parameter int unsigned DATA_BIT = 14,
    parameter int unsigned CNT_BIT  = 32,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned HYST     = 64,
    parameter int unsigned TIMEOUT  = 100_000_000
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                meas_en,
    input  logic [DATA_BIT-1:0] din,
    input  logic                din_en,
    output logic [CNT_BIT-1:0]  period_sum,
    output logic [DATA_BIT-1:0] pk_max,
    output logic [DATA_BIT-1:0] pk_min,
    output logic [DATA_BIT:0]   pk_p2p,
    output logic                meas_valid,
    output logic                no_signal,
    output logic                busy
);

    localparam int unsigned PER_W = AVG_LOG2 + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [PER_W-1:0]   PER_LAST = PER_W'((2 ** AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_BIT-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BIT-1:0] CYC_SAT  =
        (64'(TIMEOUT) > 64'(CNT_MAX)) ? CNT_MAX : CNT_BIT'(TIMEOUT);

    // With HYST=0 arming is strictly negative; otherwise din <= -HYST, i.e. din < 1-HYST.
    localparam int ARM_LT_I = (HYST == 0) ? 0 : (1 - int'(HYST));
    localparam logic signed [DATA_BIT-1:0] ARM_LT_S   = DATA_BIT'(ARM_LT_I);
    localparam logic signed [DATA_BIT-1:0] CROSS_GE_S = DATA_BIT'(HYST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        arm_q, arm_d;
    logic [CNT_BIT-1:0]          cyc_q, cyc_d;
    logic [TMO_W-1:0]            gap_q, gap_d;
    logic [PER_W-1:0]            per_q, per_d;
    logic signed [DATA_BIT-1:0]  min_q, min_d;
    logic signed [DATA_BIT-1:0]  max_q, max_d;
    logic [CNT_BIT-1:0]          period_sum_q, period_sum_d;
    logic [DATA_BIT-1:0]         pk_max_q, pk_max_d;
    logic [DATA_BIT-1:0]         pk_min_q, pk_min_d;
    logic [DATA_BIT:0]           pk_p2p_q, pk_p2p_d;
    logic                        meas_valid_q, meas_valid_d;
    logic                        no_signal_q, no_signal_d;
    logic                        busy_q, busy_d;

    logic signed [DATA_BIT-1:0]  din_s;
    logic                        cross_c;
    logic                        arm_set_c;
    logic                        tmo_c;
    logic signed [DATA_BIT-1:0]  max_c, min_c;
    logic signed [DATA_BIT:0]    ext_max_c, ext_min_c;

    // Crossing detector and running extremes including the current sample
    always_comb begin
        din_s     = signed'(din);
        cross_c   = din_en && arm_q && (din_s >= CROSS_GE_S);
        arm_set_c = din_en && (din_s < ARM_LT_S);
        tmo_c     = (gap_q == TMO_LAST) && !cross_c;
        max_c     = (din_s > max_q) ? din_s : max_q;
        min_c     = (din_s < min_q) ? din_s : min_q;
        ext_max_c = (DATA_BIT+1)'(max_c);
        ext_min_c = (DATA_BIT+1)'(min_c);
    end

    // Next-state and result logic
    always_comb begin
        state_d      = state_q;
        arm_d        = arm_q;
        cyc_d        = cyc_q;
        gap_d        = gap_q;
        per_d        = per_q;
        min_d        = min_q;
        max_d        = max_q;
        period_sum_d = period_sum_q;
        pk_max_d     = pk_max_q;
        pk_min_d     = pk_min_q;
        pk_p2p_d     = pk_p2p_q;
        meas_valid_d = 1'b0;
        no_signal_d  = no_signal_q;

        if (!meas_en) begin
            state_d     = S_IDLE;
            arm_d       = 1'b0;
            no_signal_d = 1'b0;
        end else begin
            if (cross_c) begin
                arm_d = 1'b0;
            end else if (arm_set_c) begin
                arm_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    arm_d   = 1'b0;
                    cyc_d   = '0;
                    gap_d   = '0;
                    per_d   = '0;
                    min_d   = '0;
                    max_d   = '0;
                    state_d = S_ARM;
                end
                S_ARM: begin
                    if (cross_c) begin
                        state_d = S_MEAS;
                        cyc_d   = '0;
                        per_d   = '0;
                        gap_d   = '0;
                        min_d   = din_s;
                        max_d   = din_s;
                    end else if (tmo_c) begin
                        no_signal_d = 1'b1;
                        gap_d       = '0;
                    end else begin
                        gap_d = gap_q + TMO_W'(1);
                    end
                end
                S_MEAS: begin
                    cyc_d = (cyc_q == CYC_SAT) ? cyc_q : cyc_q + CNT_BIT'(1);
                    if (din_en) begin
                        min_d = min_c;
                        max_d = max_c;
                    end
                    if (cross_c) begin
                        gap_d = '0;
                        if (per_q == PER_LAST) begin
                            // Closing crossing also opens the next window
                            period_sum_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_BIT'(1);
                            pk_max_d     = max_c;
                            pk_min_d     = min_c;
                            pk_p2p_d     = unsigned'(ext_max_c - ext_min_c);
                            meas_valid_d = 1'b1;
                            no_signal_d  = 1'b0;
                            per_d        = '0;
                            cyc_d        = '0;
                            min_d        = din_s;
                            max_d        = din_s;
                        end else begin
                            per_d = per_q + PER_W'(1);
                        end
                    end else if (tmo_c) begin
                        no_signal_d = 1'b1;
                        state_d     = S_ARM;
                        gap_d       = '0;
                    end else begin
                        gap_d = gap_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and result registers
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            arm_q        <= 1'b0;
            cyc_q        <= '0;
            gap_q        <= '0;
            per_q        <= '0;
            min_q        <= '0;
            max_q        <= '0;
            period_sum_q <= '0;
            pk_max_q     <= '0;
            pk_min_q     <= '0;
            pk_p2p_q     <= '0;
            meas_valid_q <= 1'b0;
            no_signal_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            arm_q        <= arm_d;
            cyc_q        <= cyc_d;
            gap_q        <= gap_d;
            per_q        <= per_d;
            min_q        <= min_d;
            max_q        <= max_d;
            period_sum_q <= period_sum_d;
            pk_max_q     <= pk_max_d;
            pk_min_q     <= pk_min_d;
            pk_p2p_q     <= pk_p2p_d;
            meas_valid_q <= meas_valid_d;
            no_signal_q  <= no_signal_d;
            busy_q       <= busy_d;
        end
    end

    assign period_sum = period_sum_q;
    assign pk_max     = pk_max_q;
    assign pk_min     = pk_min_q;
    assign pk_p2p     = pk_p2p_q;
    assign meas_valid = meas_valid_q;
    assign no_signal  = no_signal_q;
    assign busy       = busy_q;

endmodule
